// File: rtl/regfile_operand_fetch.sv
// Operand fetch for a 16x32 dual-read register file: scoreboard
// hazard stall, writeback forwarding and a 1-deep operand output stage.
module regfile_operand_fetch #(
  parameter int DATA_W   = 32,
  parameter int REG_AW   = 4,
  parameter int NUM_REGS = 16,
  parameter int STALL_W  = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                issue_valid,
  output logic                issue_ready,
  input  logic [REG_AW-1:0]   issue_rs0,
  input  logic [REG_AW-1:0]   issue_rs1,
  input  logic [REG_AW-1:0]   issue_rd,
  input  logic                issue_rd_en,
  input  logic                wb_valid,
  input  logic [REG_AW-1:0]   wb_rd,
  input  logic [DATA_W-1:0]   wb_data,
  output logic                rf_we,
  output logic [REG_AW-1:0]   rf_regsel_dest,
  output logic [DATA_W-1:0]   rf_datain,
  output logic [REG_AW-1:0]   rf_regsel_source0,
  output logic [REG_AW-1:0]   rf_regsel_source1,
  input  logic [DATA_W-1:0]   rf_dataout0,
  input  logic [DATA_W-1:0]   rf_dataout1,
  output logic                op_valid,
  input  logic                op_ready,
  output logic [DATA_W-1:0]   op_a,
  output logic [DATA_W-1:0]   op_b,
  output logic [REG_AW-1:0]   op_rd,
  output logic                op_rd_en,
  output logic [NUM_REGS-1:0] scoreboard,
  output logic [STALL_W-1:0]  stall_cnt,
  output logic                wb_err
);

  localparam logic [STALL_W-1:0] STALL_ONE = STALL_W'(1);

  logic [NUM_REGS-1:0] busy;
  logic [NUM_REGS-1:0] clr;
  logic [NUM_REGS-1:0] set_v;
  logic [NUM_REGS-1:0] eff_busy;
  logic [DATA_W-1:0]   fwd_a;
  logic [DATA_W-1:0]   fwd_b;
  logic                hazard;
  logic                accept;

  assign rf_we             = wb_valid & reset;
  assign rf_regsel_dest    = wb_rd;
  assign rf_datain         = wb_data;
  assign rf_regsel_source0 = issue_rs0;
  assign rf_regsel_source1 = issue_rs1;

  // The DPRF returns the old value on a same-cycle write, so bypass it.
  assign fwd_a = (wb_valid && wb_rd == issue_rs0) ? wb_data : rf_dataout0;
  assign fwd_b = (wb_valid && wb_rd == issue_rs1) ? wb_data : rf_dataout1;

  always_comb begin
    clr = '0;
    if (wb_valid) clr[wb_rd] = 1'b1;
  end

  assign eff_busy = busy & ~clr;

  assign hazard = eff_busy[issue_rs0]
                | eff_busy[issue_rs1]
                | (issue_rd_en & eff_busy[issue_rd]);

  assign issue_ready = reset && !hazard
                    && (!op_valid || op_ready);
  assign accept      = issue_valid && issue_ready;

  always_comb begin
    set_v = '0;
    if (accept && issue_rd_en) set_v[issue_rd] = 1'b1;
  end

  assign scoreboard = busy;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      op_valid  <= 1'b0;
      op_a      <= '0;
      op_b      <= '0;
      op_rd     <= '0;
      op_rd_en  <= 1'b0;
      busy      <= '0;
      stall_cnt <= '0;
      wb_err    <= 1'b0;
    end else begin
      if (accept) begin
        op_valid <= 1'b1;
        op_a     <= fwd_a;
        op_b     <= fwd_b;
        op_rd    <= issue_rd;
        op_rd_en <= issue_rd_en;
      end else if (op_ready) begin
        op_valid <= 1'b0;
      end
      busy <= (busy & ~clr) | set_v;
      if (wb_valid && !busy[wb_rd]) wb_err <= 1'b1;
      if (issue_valid && hazard && stall_cnt != '1)
        stall_cnt <= stall_cnt + STALL_ONE;
    end
  end

endmodule

// File: tb/tb_regfile_operand_fetch.sv
// Directed-vector bench for regfile_operand_fetch with a behavioural
// DPRF model; stall counter narrowed so saturation is reachable.
module tb_regfile_operand_fetch;

  localparam int SW = 4;

  typedef struct {
    logic        iv;
    logic [3:0]  rs0, rs1, rd;
    logic        en;
    logic        wv;
    logic [3:0]  wrd;
    logic [31:0] wd;
    logic        ordy;
    logic        e_ir;
    logic        e_ov;
    logic [31:0] e_a, e_b;
    logic [15:0] e_sb;
    logic [SW-1:0] e_st;
    logic        e_err;
  } vec_t;

  logic          clk, reset;
  logic          issue_valid, issue_ready;
  logic [3:0]    issue_rs0, issue_rs1, issue_rd;
  logic          issue_rd_en;
  logic          wb_valid;
  logic [3:0]    wb_rd;
  logic [31:0]   wb_data;
  logic          rf_we;
  logic [3:0]    rf_regsel_dest, rf_regsel_source0, rf_regsel_source1;
  logic [31:0]   rf_datain, rf_dataout0, rf_dataout1;
  logic          op_valid, op_ready;
  logic [31:0]   op_a, op_b;
  logic [3:0]    op_rd;
  logic          op_rd_en;
  logic [15:0]   scoreboard;
  logic [SW-1:0] stall_cnt;
  logic          wb_err;

  logic [31:0] rf_mem [16];
  int n_vec = 0;
  int n_err = 0;
  vec_t tv [22];

  regfile_operand_fetch #(.STALL_W(SW)) dut (
    .clk(clk), .reset(reset),
    .issue_valid(issue_valid), .issue_ready(issue_ready),
    .issue_rs0(issue_rs0), .issue_rs1(issue_rs1),
    .issue_rd(issue_rd), .issue_rd_en(issue_rd_en),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
    .rf_we(rf_we), .rf_regsel_dest(rf_regsel_dest),
    .rf_datain(rf_datain),
    .rf_regsel_source0(rf_regsel_source0),
    .rf_regsel_source1(rf_regsel_source1),
    .rf_dataout0(rf_dataout0), .rf_dataout1(rf_dataout1),
    .op_valid(op_valid), .op_ready(op_ready),
    .op_a(op_a), .op_b(op_b),
    .op_rd(op_rd), .op_rd_en(op_rd_en),
    .scoreboard(scoreboard), .stall_cnt(stall_cnt),
    .wb_err(wb_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk)
    if (rf_we) rf_mem[rf_regsel_dest] <= rf_datain;

  assign rf_dataout0 = rf_mem[rf_regsel_source0];
  assign rf_dataout1 = rf_mem[rf_regsel_source1];

  function automatic vec_t mk(
    input logic iv, input logic [3:0] rs0, rs1, rd,
    input logic en, wv, input logic [3:0] wrd,
    input logic [31:0] wd, input logic ordy, e_ir, e_ov,
    input logic [31:0] e_a, e_b, input logic [15:0] e_sb,
    input logic [SW-1:0] e_st, input logic e_err);
    vec_t v;
    v.iv = iv; v.rs0 = rs0; v.rs1 = rs1; v.rd = rd;
    v.en = en; v.wv = wv; v.wrd = wrd; v.wd = wd;
    v.ordy = ordy; v.e_ir = e_ir; v.e_ov = e_ov;
    v.e_a = e_a; v.e_b = e_b; v.e_sb = e_sb;
    v.e_st = e_st; v.e_err = e_err;
    return v;
  endfunction

  task automatic chk(input string nm, input int idx,
                     input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s[%0d] got %h want %h", nm, idx, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    issue_valid = v.iv;
    issue_rs0   = v.rs0;
    issue_rs1   = v.rs1;
    issue_rd    = v.rd;
    issue_rd_en = v.en;
    wb_valid    = v.wv;
    wb_rd       = v.wrd;
    wb_data     = v.wd;
    op_ready    = v.ordy;
  endtask

  initial begin
    for (int i = 0; i < 16; i++) rf_mem[i] = '0;
    reset = 1'b0;
    drive(mk(0,0,0,0,0,0,0,0,1,0,0,0,0,0,0,0));

    //  iv rs0 rs1 rd en wv wrd wd  ordy | ir ov a b sb st err
    tv[0]  = mk(1,0,0,3,1, 0,0,0, 1, 1,1,0,0,16'h0008,0,0);
    tv[1]  = mk(0,0,0,0,0, 1,3,30, 1, 1,0,0,0,16'h0000,0,0);
    tv[2]  = mk(1,3,0,1,0, 0,0,0, 1, 1,1,30,0,16'h0000,0,0);
    tv[3]  = mk(1,0,0,10,1, 0,0,0, 1, 1,1,0,0,16'h0400,0,0);
    tv[4]  = mk(1,0,10,0,0, 0,0,0, 1, 0,0,0,0,16'h0400,1,0);
    tv[5]  = mk(1,0,10,0,0, 0,0,0, 1, 0,0,0,0,16'h0400,2,0);
    tv[6]  = mk(1,0,10,0,0, 1,10,100, 1, 1,1,0,100,16'h0000,2,0);
    tv[7]  = mk(1,3,10,0,0, 0,0,0, 1, 1,1,30,100,16'h0000,2,0);
    for (int i = 8; i < 13; i++)
      tv[i] = mk(1,10,3,0,0, 0,0,0, 0, 0,1,30,100,16'h0000,2,0);
    tv[13] = mk(1,10,3,0,0, 0,0,0, 1, 1,1,100,30,16'h0000,2,0);
    tv[14] = mk(1,0,0,5,1, 0,0,0, 1, 1,1,0,0,16'h0020,2,0);
    tv[15] = mk(1,0,0,5,1, 1,5,55, 1, 1,1,0,0,16'h0020,2,0);
    tv[16] = mk(1,5,0,0,0, 0,0,0, 1, 0,0,0,0,16'h0020,3,0);
    tv[17] = mk(1,0,0,5,1, 0,0,0, 1, 0,0,0,0,16'h0020,4,0);
    tv[18] = mk(0,0,0,0,0, 1,5,77, 1, 1,0,0,0,16'h0000,4,0);
    tv[19] = mk(0,0,0,0,0, 1,7,42, 1, 1,0,0,0,16'h0000,4,1);
    tv[20] = mk(1,7,5,0,0, 0,0,0, 1, 1,1,42,77,16'h0000,4,1);
    tv[21] = mk(1,2,2,0,0, 1,2,32'h12345678, 1,
                1,1,32'h12345678,32'h12345678,16'h0000,4,1);

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ov", 0, op_valid, 0);
    chk("rst_sb", 0, scoreboard, 0);
    chk("rst_st", 0, stall_cnt, 0);
    chk("rst_err", 0, wb_err, 0);
    chk("rst_ir", 0, issue_ready, 0);
    reset = 1'b1;

    for (int i = 0; i < 22; i++) begin
      @(negedge clk);
      drive(tv[i]);
      #1;
      chk("issue_ready", i, issue_ready, tv[i].e_ir);
      chk("rf_we", i, rf_we, tv[i].wv);
      @(posedge clk);
      #1;
      chk("op_valid", i, op_valid, tv[i].e_ov);
      if (tv[i].e_ov) begin
        chk("op_a", i, op_a, tv[i].e_a);
        chk("op_b", i, op_b, tv[i].e_b);
      end
      chk("scoreboard", i, scoreboard, tv[i].e_sb);
      chk("stall_cnt", i, stall_cnt, tv[i].e_st);
      chk("wb_err", i, wb_err, tv[i].e_err);
    end

    // Saturation: hold a RAW hazard on r9 well past 2**SW cycles.
    @(negedge clk);
    drive(mk(1,0,0,9,1, 0,0,0, 1, 0,0,0,0,0,0,0));
    @(posedge clk);
    #1;
    chk("sat_rd", 0, op_rd, 9);
    chk("sat_rd_en", 0, op_rd_en, 1);
    chk("sat_sb", 0, scoreboard, 16'h0200);
    @(negedge clk);
    drive(mk(1,9,0,0,0, 0,0,0, 0, 0,0,0,0,0,0,0));
    repeat (20) @(posedge clk);
    #1;
    chk("sat_st", 0, stall_cnt, 15);
    chk("sat_ov", 0, op_valid, 1);

    // Asynchronous reset mid-stream with a bundle held.
    @(negedge clk);
    #2;
    wb_valid = 1'b1;
    wb_rd    = 4'd9;
    wb_data  = 32'hdead;
    reset    = 1'b0;
    #1;
    chk("arst_ov", 0, op_valid, 0);
    chk("arst_a", 0, op_a, 0);
    chk("arst_sb", 0, scoreboard, 0);
    chk("arst_st", 0, stall_cnt, 0);
    chk("arst_err", 0, wb_err, 0);
    chk("arst_ir", 0, issue_ready, 0);
    chk("arst_we", 0, rf_we, 0);
    @(negedge clk);
    drive(mk(1,9,0,0,0, 0,0,0, 1, 0,0,0,0,0,0,0));
    reset = 1'b1;
    #1;
    chk("post_rst_ir", 0, issue_ready, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
